// File: rtl/car_park_gate_controller_if.sv
// Board-side signal bundle for the car park gate: sensors and password digits in,
// LEDs and seven-segment digits out.
interface car_park_gate_controller_if;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  modport master (
    output sensor_entrance, sensor_exit, password_1, password_2,
    input  GREEN_LED, RED_LED, HEX_1, HEX_2
  );

  modport slave (
    input  sensor_entrance, sensor_exit, password_1, password_2,
    output GREEN_LED, RED_LED, HEX_1, HEX_2
  );
endinterface

// File: rtl/car_park_gate_controller.sv
// Parking gate FSM: waits a fixed window for a two-part password, then grants entry,
// flags an error, or blocks a tailgating car. LEDs and digits are registered from the state.
module car_park_gate_controller #(
  parameter logic [1:0]  PASS1       = 2'b01,
  parameter logic [1:0]  PASS2       = 2'b10,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input logic                          clk,
  input logic                          reset_n,
  car_park_gate_controller_if.slave    gate
);

  localparam int unsigned CntW = ($clog2(WAIT_CYCLES + 1) > 3) ? $clog2(WAIT_CYCLES + 1) : 3;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HexBlank = 7'b1111111;
  localparam logic [6:0] HexE     = 7'b0000110;
  localparam logic [6:0] HexN     = 7'b0101011;
  localparam logic [6:0] HexG     = 7'b0000010;
  localparam logic [6:0] HexO     = 7'b1000000;
  localparam logic [6:0] HexS     = 7'b0010010;
  localparam logic [6:0] HexP     = 7'b0001100;

  typedef enum logic [2:0] {
    StIdle         = 3'd0,
    StWaitPassword = 3'd1,
    StWrongPass    = 3'd2,
    StRightPass    = 3'd3,
    StStop         = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            green_q, green_d;
  logic            red_q, red_d;
  logic [6:0]      hex1_q, hex1_d;
  logic [6:0]      hex2_q, hex2_d;
  logic            pass_ok;

  assign pass_ok = (gate.password_1 == PASS1) && (gate.password_2 == PASS2);

  always_comb begin
    state_d = StIdle;
    cnt_d   = '0;
    case (state_q)
      StIdle: state_d = gate.sensor_entrance ? StWaitPassword : StIdle;
      StWaitPassword: begin
        if (cnt_q >= CntMax) begin
          state_d = pass_ok ? StRightPass : StWrongPass;
        end else begin
          state_d = StWaitPassword;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StWrongPass: state_d = pass_ok ? StRightPass : StWrongPass;
      StRightPass: begin
        if (gate.sensor_entrance && gate.sensor_exit) begin
          state_d = StStop;
        end else if (gate.sensor_exit) begin
          state_d = StIdle;
        end else begin
          state_d = StRightPass;
        end
      end
      StStop:  state_d = pass_ok ? StRightPass : StStop;
      default: state_d = StIdle;
    endcase
  end

  // Outputs follow the current state one edge later; blinking LEDs invert their own register
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = HexBlank;
    hex2_d  = HexBlank;
    case (state_q)
      StWaitPassword: begin
        red_d  = 1'b1;
        hex1_d = HexE;
        hex2_d = HexN;
      end
      StWrongPass: begin
        red_d  = ~red_q;
        hex1_d = HexE;
        hex2_d = HexE;
      end
      StRightPass: begin
        green_d = ~green_q;
        hex1_d  = HexG;
        hex2_d  = HexO;
      end
      StStop: begin
        red_d  = ~red_q;
        hex1_d = HexS;
        hex2_d = HexP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      hex1_q  <= HexBlank;
      hex2_q  <= HexBlank;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      green_q <= green_d;
      red_q   <= red_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign gate.GREEN_LED = green_q;
  assign gate.RED_LED   = red_q;
  assign gate.HEX_1     = hex1_q;
  assign gate.HEX_2     = hex2_q;

endmodule

// File: tb/tb_car_park_gate_controller.sv
// Scoreboard bench for the car park gate: a behavioural model predicts the board outputs
// each cycle and a monitor compares them one edge later.
module tb_car_park_gate_controller;

  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
  localparam int         WAIT_N = 4;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_N = 7'b0101011;
  localparam logic [6:0] SEG_G = 7'b0000010;
  localparam logic [6:0] SEG_O = 7'b1000000;
  localparam logic [6:0] SEG_S = 7'b0010010;
  localparam logic [6:0] SEG_P = 7'b0001100;

  typedef struct packed {
    logic       g;
    logic       r;
    logic [6:0] h1;
    logic [6:0] h2;
  } obs_t;

  typedef enum int {MIdle, MEntering, MDenied, MAdmitted, MBlocked} mode_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  obs_t  sb_q[$];
  mode_t m_mode = MIdle;
  int    m_elapsed = 0;
  obs_t  m_out = {1'b0, 1'b0, BLANK, BLANK};

  car_park_gate_controller_if gate_if ();

  car_park_gate_controller #(
    .PASS1       (P1),
    .PASS2       (P2),
    .WAIT_CYCLES (WAIT_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gate    (gate_if)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {gate_if.GREEN_LED, gate_if.RED_LED, gate_if.HEX_1, gate_if.HEX_2};
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got g=%b r=%b h1=%b h2=%b, want g=%b r=%b h1=%b h2=%b at %0t", name,
               got.g, got.r, got.h1, got.h2, want.g, want.r, want.h1, want.h2, $time);
    end
  endtask

  task automatic check_reset(input string name);
    compare(name, observe(), {1'b0, 1'b0, BLANK, BLANK});
  endtask

  // Reference model: one step per rising edge, driven from the pre-edge inputs
  task automatic model_step();
    logic ok;
    ok = (gate_if.password_1 == P1) && (gate_if.password_2 == P2);
    case (m_mode)
      MIdle:     m_out = {1'b0, 1'b0, BLANK, BLANK};
      MEntering: m_out = {1'b0, 1'b1, SEG_E, SEG_N};
      MDenied:   m_out = {1'b0, ~m_out.r, SEG_E, SEG_E};
      MAdmitted: m_out = {~m_out.g, 1'b0, SEG_G, SEG_O};
      MBlocked:  m_out = {1'b0, ~m_out.r, SEG_S, SEG_P};
      default:   m_out = {1'b0, 1'b0, BLANK, BLANK};
    endcase
    case (m_mode)
      MIdle: if (gate_if.sensor_entrance) begin
        m_mode    = MEntering;
        m_elapsed = 0;
      end
      MEntering: begin
        m_elapsed++;
        if (m_elapsed == WAIT_N + 1) m_mode = ok ? MAdmitted : MDenied;
      end
      MDenied, MBlocked: if (ok) m_mode = MAdmitted;
      MAdmitted: begin
        if (gate_if.sensor_exit) m_mode = gate_if.sensor_entrance ? MBlocked : MIdle;
      end
      default: m_mode = MIdle;
    endcase
    sb_q.push_back(m_out);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_mode    = MIdle;
        m_elapsed = 0;
        m_out     = {1'b0, 1'b0, BLANK, BLANK};
        sb_q.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin
    logic expect_out;
    obs_t want;
    forever begin
      @(posedge clk);
      expect_out = reset_n;
      #1;
      if (expect_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got no expected entry, want one at %0t", $time);
        end else begin
          want = sb_q.pop_front();
          compare("cycle_out", observe(), want);
        end
      end
    end
  end

  task automatic drive(input logic ent, input logic ex, input logic [1:0] a, input logic [1:0] b,
                       input int n);
    @(negedge clk);
    gate_if.sensor_entrance = ent;
    gate_if.sensor_exit     = ex;
    gate_if.password_1      = a;
    gate_if.password_2      = b;
    repeat (n) @(posedge clk);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset(name);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    gate_if.sensor_entrance = 1'b0;
    gate_if.sensor_exit     = 1'b0;
    gate_if.password_1      = 2'b00;
    gate_if.password_2      = 2'b00;
    #100;
    check_reset("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;

    // Wrong password during the window, then correct password
    drive(1'b1, 1'b0, 2'd0, 2'd0, 50);
    drive(1'b0, 1'b0, 2'd1, 2'd2, 4);
    // Exit, then stay idle
    drive(1'b0, 1'b1, 2'd1, 2'd2, 1);
    drive(1'b0, 1'b0, 2'd1, 2'd2, 4);
    // Direct correct entry
    drive(1'b1, 1'b0, 2'd1, 2'd2, 1);
    drive(1'b0, 1'b0, 2'd1, 2'd2, 9);
    // Tailgate: wrong password holds STOP, right password returns to GO
    drive(1'b1, 1'b1, 2'd3, 2'd3, 1);
    drive(1'b0, 1'b0, 2'd3, 2'd3, 5);
    drive(1'b0, 1'b0, 2'd1, 2'd2, 3);
    drive(1'b1, 1'b1, 2'd3, 2'd3, 1);
    drive(1'b0, 1'b0, 2'd3, 2'd3, 3);
    async_reset("async_mid_stop");
    drive(1'b0, 1'b0, 2'd0, 2'd0, 2);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset("random_async");
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 1) == 0) ? P1 : 2'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 0) ? P2 : 2'($urandom_range(0, 3)), 1);
    end

    drive(1'b0, 1'b0, 2'd0, 2'd0, 3);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
